// File: rtl/hazard_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Register-address width, the x0 address and the controller state encoding.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    StRun,
    StMemWait,
    StFault
  } state_e;

endpackage

// File: rtl/hazard_lu_detect.sv
// Combinational load-use hazard comparator: a load in ID/EX whose destination
// is read by the IF/ID instruction. x0 never creates a hazard.
module hazard_lu_detect
  import hazard_pkg::*;
(
  input  logic                  mem_read_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic [REG_ADDR_W-1:0] rs1_addr_i,
  input  logic [REG_ADDR_W-1:0] rs2_addr_i,
  output logic                  stall_o
);

  assign stall_o = mem_read_i && (rd_addr_i != REG_ZERO) &&
                   ((rd_addr_i == rs1_addr_i) || (rd_addr_i == rs2_addr_i));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch redirect,
// data-memory freeze with timeout fault. Define HAZARD_CTRL_PERF_EN for event counters.
module pipeline_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  IDEX_MemRead_i,
  input  logic [REG_ADDR_W-1:0] IDEX_RDaddr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS1addr_i,
  input  logic [REG_ADDR_W-1:0] IFID_RS2addr_i,
  input  logic                  EXMEM_Branch_i,
  input  logic                  EXMEM_Zero_i,
  input  logic                  dmem_busy_i,
  output logic                  PCWrite_o,
  output logic                  PCSrc_o,
  output logic                  IFID_Write_o,
  output logic                  IFID_Flush_o,
  output logic                  IDEX_Flush_o,
  output logic                  EXMEM_Flush_o,
  output logic                  Pipe_Hold_o,
  output logic                  fault_o
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]           perf_lu_stall_o,
  output logic [31:0]           perf_flush_o,
  output logic [31:0]           perf_mem_wait_o
`endif
);

  localparam logic [CNT_W-1:0] TimeoutCnt = CNT_W'(MEM_TIMEOUT);
  localparam logic [CNT_W-1:0] CntOne     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CntMax     = '1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             freeze;
  logic             lu_stall;
  logic             br_taken;

  hazard_lu_detect u_lu_detect (
    .mem_read_i (IDEX_MemRead_i),
    .rd_addr_i  (IDEX_RDaddr_i),
    .rs1_addr_i (IFID_RS1addr_i),
    .rs2_addr_i (IFID_RS2addr_i),
    .stall_o    (lu_stall)
  );

  assign br_taken = EXMEM_Branch_i & EXMEM_Zero_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StRun;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state; counter tracks consecutive busy cycles including the first one seen in RUN.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    freeze  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (dmem_busy_i) begin
          freeze  = 1'b1;
          cnt_d   = CntOne;
          state_d = (TimeoutCnt <= CntOne) ? StFault : StMemWait;
        end
      end
      StMemWait: begin
        if (dmem_busy_i) begin
          freeze  = 1'b1;
          cnt_d   = (cnt_q != CntMax) ? cnt_q + 1'b1 : cnt_q;
          state_d = (cnt_d >= TimeoutCnt) ? StFault : StMemWait;
        end else begin
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StFault: freeze = 1'b1;
      default: state_d = StRun;
    endcase
  end

  // Mealy output decode: reset > freeze > taken branch > load-use > normal.
  always_comb begin
    PCWrite_o     = 1'b1;
    PCSrc_o       = 1'b0;
    IFID_Write_o  = 1'b1;
    IFID_Flush_o  = 1'b0;
    IDEX_Flush_o  = 1'b0;
    EXMEM_Flush_o = 1'b0;
    Pipe_Hold_o   = 1'b0;
    if (rst_i) begin
      PCWrite_o     = 1'b0;
      IFID_Write_o  = 1'b0;
      IFID_Flush_o  = 1'b1;
      IDEX_Flush_o  = 1'b1;
      EXMEM_Flush_o = 1'b1;
    end else if (freeze) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      Pipe_Hold_o  = 1'b1;
    end else if (br_taken) begin
      PCSrc_o       = 1'b1;
      IFID_Flush_o  = 1'b1;
      IDEX_Flush_o  = 1'b1;
      EXMEM_Flush_o = 1'b1;
    end else if (lu_stall) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      IDEX_Flush_o = 1'b1;
    end
  end

  assign fault_o = (state_q == StFault);

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_lu_q, perf_br_q, perf_mw_q;
  logic        lu_ev;

  // A bubble is the only decode that flushes ID/EX without flushing EX/MEM.
  assign lu_ev = IDEX_Flush_o & ~EXMEM_Flush_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      perf_lu_q <= '0;
      perf_br_q <= '0;
      perf_mw_q <= '0;
    end else begin
      perf_lu_q <= perf_lu_q + {31'd0, lu_ev};
      perf_br_q <= perf_br_q + {31'd0, PCSrc_o};
      perf_mw_q <= perf_mw_q + {31'd0, (state_q == StMemWait)};
    end
  end

  assign perf_lu_stall_o = perf_lu_q;
  assign perf_flush_o    = perf_br_q;
  assign perf_mem_wait_o = perf_mw_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a cycle model of the hazard rules plus
// directed vectors with literal expectations. Define HAZARD_CTRL_PERF_EN to also check counters.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;

  // {PCWrite, PCSrc, IFID_Write, IFID_Flush, IDEX_Flush, EXMEM_Flush, Pipe_Hold, fault}
  localparam logic [7:0] ORst    = 8'b0001_1100;
  localparam logic [7:0] ONorm   = 8'b1010_0000;
  localparam logic [7:0] OBranch = 8'b1111_1100;
  localparam logic [7:0] OLu     = 8'b0000_1000;
  localparam logic [7:0] OFrz    = 8'b0000_0010;
  localparam logic [7:0] OFault  = 8'b0000_0011;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       mr = 1'b0, br = 1'b0, z = 1'b0, busy = 1'b0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic       pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, hold, fault;
  logic [7:0] outs;
  int         total = 0;
  int         bad = 0;

  // Model state: consecutive busy cycles seen and sticky fault.
  int         m_run = 0;
  logic       m_fault = 1'b0;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] p_lu, p_br, p_mw;
  int          m_lu = 0, m_br = 0, m_mw = 0;
`endif

  pipeline_hazard_ctrl #(
    .MEM_TIMEOUT (TO),
    .CNT_W       (3)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .IDEX_MemRead_i (mr),
    .IDEX_RDaddr_i  (rd),
    .IFID_RS1addr_i (rs1),
    .IFID_RS2addr_i (rs2),
    .EXMEM_Branch_i (br),
    .EXMEM_Zero_i   (z),
    .dmem_busy_i    (busy),
    .PCWrite_o      (pc_write),
    .PCSrc_o        (pc_src),
    .IFID_Write_o   (ifid_write),
    .IFID_Flush_o   (ifid_flush),
    .IDEX_Flush_o   (idex_flush),
    .EXMEM_Flush_o  (exmem_flush),
    .Pipe_Hold_o    (hold),
    .fault_o        (fault)
`ifdef HAZARD_CTRL_PERF_EN
    ,
    .perf_lu_stall_o (p_lu),
    .perf_flush_o    (p_br),
    .perf_mem_wait_o (p_mw)
`endif
  );

  always #5 clk = ~clk;

  assign outs = {pc_write, pc_src, ifid_write, ifid_flush, idex_flush, exmem_flush, hold, fault};

  function automatic logic is_lu();
    return mr && (rd != 5'd0) && (rd == rs1 || rd == rs2);
  endfunction

  function automatic logic [7:0] model_out();
    if (rst) return ORst;
    if (m_fault) return OFault;
    if (busy) return OFrz;
    if (br && z) return OBranch;
    if (is_lu()) return OLu;
    return ONorm;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_run   <= 0;
      m_fault <= 1'b0;
`ifdef HAZARD_CTRL_PERF_EN
      m_lu <= 0; m_br <= 0; m_mw <= 0;
`endif
    end else begin
`ifdef HAZARD_CTRL_PERF_EN
      if (!m_fault && m_run > 0) m_mw <= m_mw + 1;
      if (!m_fault && !busy && br && z) m_br <= m_br + 1;
      if (!m_fault && !busy && !(br && z) && is_lu()) m_lu <= m_lu + 1;
`endif
      if (!m_fault) begin
        if (busy) begin
          m_run <= m_run + 1;
          if (m_run + 1 >= TO) m_fault <= 1'b1;
        end else begin
          m_run <= 0;
        end
      end
    end
  end

  // Compare process: every cycle, mid low phase.
  always @(negedge clk) begin
    logic [7:0] want;
    want = model_out();
    total = total + 1;
    if (outs !== want) begin
      bad = bad + 1;
      $display("FAIL model t=%0t got=%b want=%b", $time, outs, want);
    end
`ifdef HAZARD_CTRL_PERF_EN
    total = total + 1;
    if (p_lu !== 32'(m_lu) || p_br !== 32'(m_br) || p_mw !== 32'(m_mw)) begin
      bad = bad + 1;
      $display("FAIL perf t=%0t got=%0d/%0d/%0d want=%0d/%0d/%0d",
               $time, p_lu, p_br, p_mw, m_lu, m_br, m_mw);
    end
`endif
  end

  task automatic cyc(input logic r, input logic m, input logic [4:0] d, input logic [4:0] s1,
                     input logic [4:0] s2, input logic b, input logic zz, input logic bs);
    @(posedge clk);
    #1;
    rst = r; mr = m; rd = d; rs1 = s1; rs2 = s2; br = b; z = zz; busy = bs;
    @(negedge clk);
    #1;
  endtask

  task automatic lit(input string name, input logic [7:0] want);
    total = total + 1;
    if (outs !== want) begin
      bad = bad + 1;
      $display("FAIL %s got=%b want=%b", name, outs, want);
    end
  endtask

  initial begin
    #1 rst = 1'b1;
    cyc(1, 0, 0, 0, 0, 0, 0, 0);   lit("reset", ORst);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);   lit("after_reset", ONorm);
    cyc(0, 1, 5, 5, 0, 0, 0, 0);   lit("lu_rs1", OLu);
    cyc(0, 0, 5, 5, 0, 0, 0, 0);   lit("bubble_clears", ONorm);
    cyc(0, 1, 7, 1, 7, 0, 0, 0);   lit("lu_rs2", OLu);
    cyc(0, 1, 0, 0, 0, 0, 0, 0);   lit("x0_no_stall", ONorm);
    cyc(0, 0, 5, 5, 5, 0, 0, 0);   lit("no_load", ONorm);
    cyc(0, 1, 5, 5, 0, 1, 1, 0);   lit("branch_over_lu", OBranch);
    cyc(0, 1, 5, 5, 0, 1, 0, 0);   lit("not_taken_lu", OLu);
    cyc(0, 0, 0, 0, 0, 0, 1, 0);   lit("zero_only", ONorm);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 0, 1, 1, 1); lit("busy3_frozen", OFrz);
    end
    cyc(0, 0, 0, 0, 0, 0, 0, 0);   lit("busy3_resume", ONorm);
    cyc(0, 1, 9, 2, 3, 0, 0, 1);   lit("busy_a", OFrz);
    cyc(0, 1, 9, 2, 9, 0, 0, 1);   lit("busy_b", OFrz);
    cyc(0, 1, 9, 2, 9, 0, 0, 0);   lit("resume_lu", OLu);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);   lit("busy_c", OFrz);
    cyc(0, 0, 0, 0, 0, 1, 1, 0);   lit("resume_branch", OBranch);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 1);
    cyc(1, 0, 0, 0, 0, 0, 0, 1);   lit("reset_mid_stall", ORst);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);   lit("after_mid_reset", ONorm);
    for (int i = 1; i <= 10; i++) begin
      cyc(0, 0, 0, 0, 0, 0, 0, 1);
      lit((i <= TO) ? "timeout_frozen" : "timeout_fault", (i <= TO) ? OFrz : OFault);
    end
    cyc(0, 1, 5, 5, 0, 1, 1, 0);   lit("fault_sticky", OFault);
    cyc(1, 0, 0, 0, 0, 0, 0, 0);   lit("fault_reset", ORst);
    cyc(0, 0, 0, 0, 0, 0, 0, 0);   lit("fault_cleared", ONorm);
    @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
